glb_strm_fabric_endpoint: RTL
=============================

// Module: glb_strm_fabric_endpoint
// PURPOSE
//  Fabric-side end of the GLB streaming link. Consumes the g2f lanes that the GLB drives,
//  transforms each word, buffers it per lane, and returns it on the f2g lanes at a
//  programmable rate. Used as a synthesizable CGRA stand-in for GLB stream closure tests.
//  Asserts done once every lane has returned cfg_num_words words.
// PARAMETERS
//  CGRA_PER_GLB     4   number of stream lanes (columns per GLB tile)
//  CGRA_DATA_WIDTH  16  lane data width
//  FIFO_DEPTH       4   per-lane buffer depth, power of 2, >=2
//  CNT_WIDTH        16  word-count width
// PORTS
//  clk              in   1                  clock
//  reset            in   1                  synchronous active-high reset
//  strm_start_pulse in   1                  one-cycle start; latches cfg_*
//  cfg_num_words    in   CNT_WIDTH          words per lane per stream
//  cfg_add_const    in   CGRA_DATA_WIDTH    constant added to each g2f word
//  cfg_issue_gap    in   4                  idle cycles between f2g words per lane
//  data_g2f         in   [CGRA_PER_GLB][DW]  data from GLB
//  data_valid_g2f   in   CGRA_PER_GLB       per-lane valid from GLB
//  data_f2g         out  [CGRA_PER_GLB][DW]  data to GLB, registered
//  data_valid_f2g   out  CGRA_PER_GLB       per-lane valid to GLB, registered
//  overflow         out  CGRA_PER_GLB       sticky per-lane drop flag
//  busy             out  1                  high in ACTIVE
//  strm_done_pulse  out  1                  one-cycle stream-complete pulse
// BEHAVIOUR
//  Reset: all outputs 0, FIFOs empty, counters 0, state IDLE. Reset mid-stream flushes
//   everything, with no done pulse.
//  FSM: IDLE -start-> ACTIVE -all lanes out_cnt==num_words-> DONE -> IDLE.
//   DONE lasts 1 cycle. strm_done_pulse=1 only in DONE. busy=1 only in ACTIVE.
//   cfg_num_words==0: ACTIVE then DONE on the next cycle, with no f2g traffic.
//   A start pulse outside IDLE is ignored. cfg_* are sampled only on the start cycle.
//   g2f valid outside ACTIVE is ignored and does not set overflow.
//  Ingress, per lane i, in ACTIVE:
//   - When valid_g2f[i] is high, push (data_g2f[i]+add_const) mod 2^DW.
//   - in_cnt[i] increments on each accepted push.
//   - If in_cnt[i]==num_words, the word is dropped and overflow[i] is set.
//   - If the FIFO is full and no pop occurs in the same cycle, the word is dropped,
//     overflow[i] is set, and in_cnt is unchanged.
//   - Full with a simultaneous pop: the push is accepted.
//  Egress, per lane:
//   - gap_cnt[i] loads cfg_issue_gap after each pop and decrements to 0.
//   - A pop happens when the FIFO is non-empty and gap_cnt==0.
//   - The popped word is registered onto data_f2g[i] with valid_f2g[i]=1 for 1 cycle.
//   - Otherwise valid_f2g[i]=0 and data_f2g[i] holds its last value.
//   - out_cnt[i] increments per pop.
//  Latency: a push at cycle t into an empty FIFO with gap_cnt==0 gives valid_f2g at t+1.
//   FIFO is first-word-fall-through.
//  Throughput: 1 word per (gap+1) cycles per lane. With gap=0 a lane never fills.
//  overflow clears only on reset or on an accepted start pulse.
//  Counters never wrap: in_cnt saturates at num_words by the drop rule.
// TESTING
//  T1 reset, start with num_words=3, add_const=1, gap=0; lane0 g2f 10,20,30 on
//     consecutive cycles -> f2g lane0 11,21,31 one cycle later each; done pulse the cycle
//     after the last lane completes.
//  T2 num_words=0 and start -> busy for 1 cycle, done pulse next cycle, valid_f2g all 0.
//  T3 gap=3, FIFO_DEPTH=4; 8 back-to-back g2f words on lane1 with num_words=8
//     -> f2g valid every 4 cycles; overflow[1]=1; out_cnt stalls below 8, done absent.
//     Then reset -> all 0.
//  T4 add_const=16'h0002 with g2f data=16'hFFFF -> f2g data=16'h0001 (wrap).
//  T5 num_words=2; 3 words on lane2 -> 2 returned, overflow[2]=1. Start pulse
//     mid-ACTIVE is ignored. Next start in IDLE clears overflow.
//  T6 all 4 lanes driven with staggered valids, num_words=5, gap=1 -> each lane returns
//     5 in-order transformed words; a single done pulse after the slowest lane.
//  T7 reset asserted mid-ACTIVE with FIFOs non-empty -> next cycle all outputs 0,
//     no done, no f2g valid.

Source files
------------

// File: rtl/glb_strm_fabric_endpoint.sv
// -----------------------------------------------------------------------------
// glb_strm_fabric_endpoint
// Fabric-side end of the GLB streaming link. Each g2f lane word has a constant
// added to it and is buffered in a per-lane first-word-fall-through FIFO. It is
// then returned on the matching f2g lane at a programmable rate. strm_done_pulse
// fires once every lane has returned cfg_num_words words.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   strm_start_pulse  one-cycle start, samples cfg_* (ignored unless idle)
//   cfg_num_words     words per lane per stream
//   cfg_add_const     constant added (mod 2^DW) to every g2f word
//   cfg_issue_gap     idle cycles between f2g words on a lane
//   data_g2f          per-lane data from GLB
//   data_valid_g2f    per-lane valid from GLB
//   data_f2g          per-lane registered data to GLB (holds when not valid)
//   data_valid_f2g    per-lane registered valid to GLB
//   overflow          sticky per-lane drop flag
//   busy              stream active
//   strm_done_pulse   one-cycle stream-complete pulse
// -----------------------------------------------------------------------------
module glb_strm_fabric_endpoint #(
    parameter int CGRA_PER_GLB    = 4,
    parameter int CGRA_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          strm_start_pulse,
    input  logic [CNT_WIDTH-1:0]                          cfg_num_words,
    input  logic [CGRA_DATA_WIDTH-1:0]                    cfg_add_const,
    input  logic [3:0]                                    cfg_issue_gap,
    input  logic [CGRA_PER_GLB-1:0][CGRA_DATA_WIDTH-1:0]  data_g2f,
    input  logic [CGRA_PER_GLB-1:0]                       data_valid_g2f,
    output logic [CGRA_PER_GLB-1:0][CGRA_DATA_WIDTH-1:0]  data_f2g,
    output logic [CGRA_PER_GLB-1:0]                       data_valid_f2g,
    output logic [CGRA_PER_GLB-1:0]                       overflow,
    output logic                                          busy,
    output logic                                          strm_done_pulse
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

    state_t                      state, state_nxt;
    logic [CNT_WIDTH-1:0]        num_words_q;
    logic [CGRA_DATA_WIDTH-1:0]  add_const_q;
    logic [3:0]                  issue_gap_q;
    logic [CGRA_PER_GLB-1:0]     lane_done;
    logic                        start_acc;
    logic                        active;

    assign start_acc = (state == ST_IDLE) && strm_start_pulse;
    assign active    = (state == ST_ACTIVE);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: default assignment first, so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (strm_start_pulse) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (&lane_done)       state_nxt = ST_DONE;
            ST_DONE:                         state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy            = (state == ST_ACTIVE);
        strm_done_pulse = (state == ST_DONE);
    end

    // Configuration is captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_words_q <= '0;
            add_const_q <= '0;
            issue_gap_q <= '0;
        end else if (start_acc) begin
            num_words_q <= cfg_num_words;
            add_const_q <= cfg_add_const;
            issue_gap_q <= cfg_issue_gap;
        end
    end

    // ---------------- Per-lane datapath ----------------
    for (genvar i = 0; i < CGRA_PER_GLB; i++) begin : g_lane
        logic [CGRA_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]              wr_ptr, rd_ptr;
        logic [AW:0]                count;
        logic [CNT_WIDTH-1:0]       in_cnt, out_cnt;
        logic [3:0]                 gap_cnt;
        logic [CGRA_DATA_WIDTH-1:0] push_data, head, f2g_q;
        logic                       empty, full, push_req, push, pop, bypass;
        logic                       wr_en, rd_en, valid_q, ovf_q;

        assign empty     = (count == '0);
        assign full      = (count == (AW+1)'(FIFO_DEPTH));
        assign push_data = data_g2f[i] + add_const_q;

        // Word is wanted if the lane has not yet taken num_words words.
        assign push_req = active && data_valid_g2f[i] && (in_cnt < num_words_q);
        // Fall-through: an incoming word into an empty FIFO may leave the same cycle.
        // An empty FIFO is never full, so pop does not depend on push there (no loop).
        assign pop      = (gap_cnt == 4'd0) && (!empty || push_req);
        assign push     = push_req && (!full || pop);
        assign bypass   = empty && pop;
        assign head     = empty ? push_data : mem[rd_ptr];
        assign wr_en    = push && !bypass;
        assign rd_en    = pop && !empty;

        // NOTE: buffer storage has no reset; only pointers/count define its contents.
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr] <= push_data;
        end

        always_ff @(posedge clk) begin
            if (reset || start_acc) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                in_cnt  <= '0;
                out_cnt <= '0;
                gap_cnt <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
                unique case ({wr_en, rd_en})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
                if (push) in_cnt  <= in_cnt + CNT_WIDTH'(1);
                if (pop)  out_cnt <= out_cnt + CNT_WIDTH'(1);
                if (pop)                  gap_cnt <= issue_gap_q;
                else if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                f2g_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= pop;
                if (pop) f2g_q <= head;
            end
        end

        // Drop happens on a wanted-but-unaccepted word or a word past the count.
        always_ff @(posedge clk) begin
            if (reset || start_acc)                     ovf_q <= 1'b0;
            else if (active && data_valid_g2f[i] && !push) ovf_q <= 1'b1;
        end

        assign data_f2g[i]       = f2g_q;
        assign data_valid_f2g[i] = valid_q;
        assign overflow[i]       = ovf_q;
        assign lane_done[i]      = (out_cnt == num_words_q);
    end

endmodule
